// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Multi-cycle control sequencer for the RV32I core. Each instruction goes
// through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The unit handshakes with
// instruction and data memories that may stall, and drives the same datapath
// controls as the single-cycle decoder, gated per state. A stall longer than
// MEM_TIMEOUT cycles on either ready input parks the unit in FAULT until reset.
//
// Optional feature, selected by the macro MCU_ILLEGAL_TRAP_EN:
//   defined   - an illegal opcode parks the unit in TRAP with `trap` raised.
//   undefined - an illegal opcode retires as a NOP (PC + 4); `trap` is tied 0.
//
// Outputs are a combinational decode of the registered state and the latched
// instruction fields. The only input-to-output paths are imem_ready -> ir_write,
// dmem_ready -> store pc_write, and branch_taken -> pc_control.

module multicycle_control_unit #(
  parameter int ALU_OP_W    = 4,   // >= 4; bits above [3:0] are driven 0
  parameter int MEM_TIMEOUT = 15   // 1..255 wait cycles before a fault
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                branch_taken,
  output logic                fetch_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_control,
  output logic                imm_en,
  output logic                rf_write_en,
  output logic                mem_read_en,
  output logic                mem_write_en,
  output logic                sign_extender_en,
  output logic                sign_extender_type,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_fault,
  output logic                trap,
  output logic [2:0]          state
);

  // --------------------------------------------------------------------------
  // Types and constants
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  // Instruction classes recognised from opcode bits [6:2].
  typedef enum logic [3:0] {
    C_ILLEGAL,
    C_UPPER,     // LUI / AUIPC
    C_OPIMM,
    C_OP,
    C_LOAD,
    C_STORE,
    C_JAL,
    C_JALR,
    C_BRANCH
  } class_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_SLL = 4'b0010,
    ALU_SRL = 4'b0100,
    ALU_SRA = 4'b0101,
    ALU_XOR = 4'b0110,
    ALU_OR  = 4'b0111,
    ALU_AND = 4'b1000,
    ALU_BEQ = 4'b1001,
    ALU_BNE = 4'b1010,
    ALU_BLT = 4'b1011,
    ALU_BGE = 4'b1100,
    ALU_SLT = 4'b1101
  } alu_e;

  localparam logic [1:0] PC_HOLD   = 2'b00;
  localparam logic [1:0] PC_INC    = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_BRANCH = 2'b11;

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  // --------------------------------------------------------------------------
  // State and latched instruction fields
  // --------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [4:0]  opcode_q;    // instr[6:2]
  logic [2:0]  funct3_q;    // instr[14:12]
  logic        bit30_q;     // instr[30]

  class_e      cls;
  alu_e        alu_code;
  logic        unsigned_sel;
  logic        load_unsigned;

  // Bits of the instruction word the control path never looks at.
  logic        unused_instr;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7], instr[1:0]};

  // --------------------------------------------------------------------------
  // Register update: FSM state, wait counter and the instruction fields
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      bit30_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_q == S_FETCH && imem_ready) begin
        opcode_q <= instr[6:2];
        funct3_q <= instr[14:12];
        bit30_q  <= instr[30];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Instruction classification from the latched opcode
  // --------------------------------------------------------------------------
  always_comb begin
    case (opcode_q)
      5'b01101, 5'b00101: cls = C_UPPER;
      5'b00100:           cls = C_OPIMM;
      5'b01100:           cls = C_OP;
      5'b00000:           cls = C_LOAD;
      5'b01000:           cls = C_STORE;
      5'b11011:           cls = C_JAL;
      5'b11001:           cls = C_JALR;
      5'b11000:           cls = C_BRANCH;
      default:            cls = C_ILLEGAL;
    endcase
  end

  // --------------------------------------------------------------------------
  // ALU operation and operand signedness for the latched instruction
  // --------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_code = ALU_ADD;
    case (cls)
      C_OP, C_OPIMM: begin
        case (funct3_q)
          3'b000:         alu_code = (cls == C_OP && bit30_q) ? ALU_SUB : ALU_ADD;
          3'b001:         alu_code = ALU_SLL;
          3'b010, 3'b011: alu_code = ALU_SLT;
          3'b100:         alu_code = ALU_XOR;
          3'b101:         alu_code = bit30_q ? ALU_SRA : ALU_SRL;
          3'b110:         alu_code = ALU_OR;
          default:        alu_code = ALU_AND;
        endcase
      end
      C_BRANCH: begin
        case (funct3_q)
          3'b000:         alu_code = ALU_BEQ;
          3'b001:         alu_code = ALU_BNE;
          3'b100, 3'b110: alu_code = ALU_BLT;
          3'b101, 3'b111: alu_code = ALU_BGE;
          default:        alu_code = ALU_ADD;   // reserved branch encodings
        endcase
      end
      default: alu_code = ALU_ADD;  // address and link arithmetic
    endcase

    // Unsigned compare/extension: sltiu, sltu, bltu, bgeu, lbu, lhu.
    load_unsigned = (cls == C_LOAD) && funct3_q[2];
    unsigned_sel  = load_unsigned
                  || ((cls == C_OP || cls == C_OPIMM) && funct3_q == 3'b011)
                  || ((cls == C_BRANCH) && funct3_q[2:1] == 2'b11);
  end

  // --------------------------------------------------------------------------
  // Next-state and wait-counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_FETCH: begin
        // A ready in the same cycle as the limit still wins.
        if (imem_ready)                     state_d = S_DECODE;
        else if (wait_cnt_q == TIMEOUT_LIM) state_d = S_FAULT;
        else                                wait_cnt_d = wait_cnt_q + 8'd1;
      end
      S_DECODE: begin
        if (cls == C_ILLEGAL) begin
`ifdef MCU_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d    = S_FETCH;
          wait_cnt_d = '0;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_LOAD, C_STORE: begin
            state_d    = S_MEM;
            wait_cnt_d = '0;
          end
          C_BRANCH, C_JAL, C_JALR, C_ILLEGAL: begin
            state_d    = S_FETCH;
            wait_cnt_d = '0;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (cls == C_LOAD) begin
            state_d = S_WB;
          end else begin
            state_d    = S_FETCH;
            wait_cnt_d = '0;
          end
        end else if (wait_cnt_q == TIMEOUT_LIM) begin
          state_d = S_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_WB: begin
        state_d    = S_FETCH;
        wait_cnt_d = '0;
      end
      S_FAULT: state_d = S_FAULT;   // left only through reset
      S_TRAP:  state_d = S_TRAP;    // left only through reset
      default: begin
        state_d    = S_FETCH;
        wait_cnt_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath control decode from state and latched fields
  // --------------------------------------------------------------------------
  // NOTE: the decode is qualified by rst_n so every output, fetch_req included,
  // is 0 for as long as reset is held, not just after the next edge.
  always_comb begin
    fetch_req          = 1'b0;
    ir_write           = 1'b0;
    pc_write           = 1'b0;
    pc_control         = PC_HOLD;
    imm_en             = 1'b0;
    rf_write_en        = 1'b0;
    mem_read_en        = 1'b0;
    mem_write_en       = 1'b0;
    sign_extender_en   = 1'b0;
    sign_extender_type = 1'b0;
    alu_op             = '0;
    mem_fault          = 1'b0;
    trap               = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          fetch_req = 1'b1;
          ir_write  = imem_ready;
        end
        S_DECODE: begin
`ifdef MCU_ILLEGAL_TRAP_EN
          // Illegal opcodes move on to TRAP without any strobe here.
`else
          if (cls == C_ILLEGAL) begin
            pc_write   = 1'b1;
            pc_control = PC_INC;
          end
`endif
        end
        S_EXEC: begin
          imm_en             = (cls != C_OP);
          sign_extender_en   = (cls != C_OP);
          sign_extender_type = unsigned_sel;
          alu_op[3:0]        = alu_code;
          case (cls)
            C_BRANCH: begin
              pc_write   = 1'b1;
              pc_control = branch_taken ? PC_BRANCH : PC_INC;
            end
            C_JAL, C_JALR: begin
              rf_write_en = 1'b1;
              pc_write    = 1'b1;
              pc_control  = PC_JUMP;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (cls == C_LOAD) begin
            mem_read_en        = 1'b1;
            sign_extender_type = load_unsigned;   // extension of returned data
          end else begin
            mem_write_en = 1'b1;
            if (dmem_ready) begin
              pc_write   = 1'b1;
              pc_control = PC_INC;
            end
          end
        end
        S_WB: begin
          rf_write_en = 1'b1;
          pc_write    = 1'b1;
          pc_control  = PC_INC;
        end
        S_FAULT: mem_fault = 1'b1;
        S_TRAP: begin
`ifdef MCU_ILLEGAL_TRAP_EN
          trap = 1'b1;
`else
          trap = 1'b0;   // unreachable in this build
`endif
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit
// Directed bench for multicycle_control_unit. The stimulus process drives one
// cycle at a time and pushes the hand-computed expected output word for that
// cycle into a queue; a monitor on the falling edge pops and compares.

module tb_multicycle_control_unit;

  localparam int AW  = 6;   // wider than 4 so the zeroed upper alu_op bits are seen
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   instr = '0;
  logic          imem_ready = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          branch_taken = 1'b0;
  logic          fetch_req, ir_write, pc_write;
  logic [1:0]    pc_control;
  logic          imm_en, rf_write_en, mem_read_en, mem_write_en;
  logic          sign_extender_en, sign_extender_type;
  logic [AW-1:0] alu_op;
  logic          mem_fault, trap;
  logic [2:0]    state;

  multicycle_control_unit #(.ALU_OP_W(AW), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .fetch_req(fetch_req), .ir_write(ir_write), .pc_write(pc_write),
    .pc_control(pc_control), .imm_en(imm_en), .rf_write_en(rf_write_en),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .sign_extender_en(sign_extender_en), .sign_extender_type(sign_extender_type),
    .alu_op(alu_op), .mem_fault(mem_fault), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  // Observed output word
  typedef struct packed {
    logic [2:0]    st;
    logic          freq, irw, pcw;
    logic [1:0]    pcc;
    logic          imm, rfw, mrd, mwr, sxe, sxt;
    logic [AW-1:0] alu;
    logic          flt, trp;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  // Monitor: compare the DUT against the oldest pending expectation.
  always @(negedge clk) begin
    obs_t  a, e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a.st = state;          a.freq = fetch_req;    a.irw = ir_write;
      a.pcw = pc_write;      a.pcc = pc_control;    a.imm = imm_en;
      a.rfw = rf_write_en;   a.mrd = mem_read_en;   a.mwr = mem_write_en;
      a.sxe = sign_extender_en; a.sxt = sign_extender_type;
      a.alu = alu_op;        a.flt = mem_fault;     a.trp = trap;
      n_vec++;
      if (a !== e) begin
        n_miss++;
        $display("FAIL %s: got st=%0d fr=%b irw=%b pcw=%b pcc=%b imm=%b rfw=%b rd=%b wr=%b sxe=%b sxt=%b alu=%b flt=%b trp=%b, want st=%0d fr=%b irw=%b pcw=%b pcc=%b imm=%b rfw=%b rd=%b wr=%b sxe=%b sxt=%b alu=%b flt=%b trp=%b",
                 nm, a.st, a.freq, a.irw, a.pcw, a.pcc, a.imm, a.rfw, a.mrd, a.mwr, a.sxe, a.sxt, a.alu, a.flt, a.trp,
                 e.st, e.freq, e.irw, e.pcw, e.pcc, e.imm, e.rfw, e.mrd, e.mwr, e.sxe, e.sxt, e.alu, e.flt, e.trp);
      end
    end
  end

  // Expected-word builders
  function automatic obs_t f_st(input logic [2:0] st);
    obs_t e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic obs_t f_fetch(input logic irw);
    obs_t e = f_st(3'd0);
    e.freq = 1'b1;
    e.irw  = irw;
    return e;
  endfunction

  function automatic obs_t f_exec(input logic [3:0] alu, input logic imm, input logic sxt,
                                  input logic pcw, input logic [1:0] pcc, input logic rfw);
    obs_t e = f_st(3'd2);
    e.alu = {{(AW-4){1'b0}}, alu};
    e.imm = imm;  e.sxe = imm;  e.sxt = sxt;
    e.pcw = pcw;  e.pcc = pcc;  e.rfw = rfw;
    return e;
  endfunction

  function automatic obs_t f_mem(input logic rd, input logic wr, input logic sxt, input logic pcw);
    obs_t e = f_st(3'd3);
    e.mrd = rd;  e.mwr = wr;  e.sxt = sxt;
    e.pcw = pcw; e.pcc = pcw ? 2'b01 : 2'b00;
    return e;
  endfunction

  function automatic obs_t f_wb();
    obs_t e = f_st(3'd4);
    e.rfw = 1'b1;  e.pcw = 1'b1;  e.pcc = 2'b01;
    return e;
  endfunction

  function automatic obs_t f_fault();
    obs_t e = f_st(3'd5);
    e.flt = 1'b1;
    return e;
  endfunction

  // One clock cycle: drive inputs, queue the expectation, advance to edge + 1.
  task automatic step(input string nm, input obs_t e, input logic im, input logic dm, input logic bt);
    imem_ready   = im;
    dmem_ready   = dm;
    branch_taken = bt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    step(nm, f_st(3'd0), 1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
  endtask

  task automatic fetch(input string nm, input logic [31:0] ins, input int waits);
    instr = ins;
    for (int i = 0; i < waits; i++) step({nm, " fetch-wait"}, f_fetch(1'b0), 1'b0, 1'b0, 1'b0);
    step({nm, " fetch"}, f_fetch(1'b1), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_alu(input string nm, input logic [31:0] ins, input int fw,
                         input logic [3:0] alu, input logic imm, input logic sxt);
    fetch(nm, ins, fw);
    step({nm, " decode"}, f_st(3'd1), 1'b0, 1'b0, 1'b0);
    step({nm, " exec"}, f_exec(alu, imm, sxt, 1'b0, 2'b00, 1'b0), 1'b0, 1'b0, 1'b0);
    step({nm, " wb"}, f_wb(), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_br(input string nm, input logic [31:0] ins, input logic [3:0] alu,
                        input logic sxt, input logic bt);
    fetch(nm, ins, 0);
    step({nm, " decode"}, f_st(3'd1), 1'b0, 1'b0, 1'b0);
    step({nm, " exec"}, f_exec(alu, 1'b1, sxt, 1'b1, bt ? 2'b11 : 2'b01, 1'b0), 1'b0, 1'b0, bt);
  endtask

  task automatic run_jmp(input string nm, input logic [31:0] ins);
    fetch(nm, ins, 0);
    step({nm, " decode"}, f_st(3'd1), 1'b0, 1'b0, 1'b0);
    step({nm, " exec"}, f_exec(4'b0000, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_ld(input string nm, input logic [31:0] ins, input logic sxt, input int waits);
    fetch(nm, ins, 0);
    step({nm, " decode"}, f_st(3'd1), 1'b0, 1'b0, 1'b0);
    step({nm, " exec"}, f_exec(4'b0000, 1'b1, sxt, 1'b0, 2'b00, 1'b0), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < waits; i++) step({nm, " mem-wait"}, f_mem(1'b1, 1'b0, sxt, 1'b0), 1'b0, 1'b0, 1'b0);
    step({nm, " mem"}, f_mem(1'b1, 1'b0, sxt, 1'b0), 1'b0, 1'b1, 1'b0);
    step({nm, " wb"}, f_wb(), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_st(input string nm, input logic [31:0] ins, input int waits);
    fetch(nm, ins, 0);
    step({nm, " decode"}, f_st(3'd1), 1'b0, 1'b0, 1'b0);
    step({nm, " exec"}, f_exec(4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < waits; i++) step({nm, " mem-wait"}, f_mem(1'b0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0);
    step({nm, " mem"}, f_mem(1'b0, 1'b1, 1'b0, 1'b1), 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    obs_t e;
    @(posedge clk);
    #1;
    do_reset("reset");

    // Register-register and immediate ALU ops (4 cycles each)
    run_alu("add",   32'h0000_0033, 0, 4'b0000, 1'b0, 1'b0);
    run_alu("sub",   32'h4000_0033, 0, 4'b0001, 1'b0, 1'b0);
    run_alu("sll",   32'h0000_1033, 0, 4'b0010, 1'b0, 1'b0);
    run_alu("sltu",  32'h0000_3033, 0, 4'b1101, 1'b0, 1'b1);
    run_alu("srl",   32'h0000_5033, 0, 4'b0100, 1'b0, 1'b0);
    run_alu("sra",   32'h4000_5033, 0, 4'b0101, 1'b0, 1'b0);
    run_alu("or",    32'h0000_6033, 0, 4'b0111, 1'b0, 1'b0);
    run_alu("and",   32'h0000_7033, 0, 4'b1000, 1'b0, 1'b0);
    run_alu("addi30",32'h4000_0013, 0, 4'b0000, 1'b1, 1'b0);
    run_alu("slti",  32'h0000_2013, 0, 4'b1101, 1'b1, 1'b0);
    run_alu("sltiu", 32'h0000_3013, 0, 4'b1101, 1'b1, 1'b1);
    run_alu("xori",  32'h0000_4013, 0, 4'b0110, 1'b1, 1'b0);
    run_alu("srai",  32'h4000_5013, 0, 4'b0101, 1'b1, 1'b0);
    run_alu("lui",   32'h0000_0037, 0, 4'b0000, 1'b1, 1'b0);
    run_alu("auipc", 32'h0000_0017, 0, 4'b0000, 1'b1, 1'b0);

    // Branches and jumps (3 cycles each)
    run_br("bltu-t", 32'h0000_6063, 4'b1011, 1'b1, 1'b1);
    run_br("bltu-n", 32'h0000_6063, 4'b1011, 1'b1, 1'b0);
    run_br("beq",    32'h0000_0063, 4'b1001, 1'b0, 1'b1);
    run_br("bne",    32'h0000_1063, 4'b1010, 1'b0, 1'b0);
    run_br("blt",    32'h0000_4063, 4'b1011, 1'b0, 1'b1);
    run_br("bge",    32'h0000_5063, 4'b1100, 1'b0, 1'b1);
    run_br("bgeu",   32'h0000_7063, 4'b1100, 1'b1, 1'b0);
    run_jmp("jal",   32'h0000_006F);
    run_jmp("jalr",  32'h0000_0067);

    // Memory accesses with and without data-memory wait
    run_ld("lbu", 32'h0000_4003, 1'b1, 3);
    run_ld("lw",  32'h0000_2003, 1'b0, 0);
    run_ld("lhu", 32'h0000_5003, 1'b1, 1);
    run_st("sw",  32'h0000_2023, 0);
    run_st("sb",  32'h0000_0023, 2);

    // Illegal opcode
`ifdef MCU_ILLEGAL_TRAP_EN
    fetch("illegal", 32'h0000_007F, 0);
    step("illegal decode", f_st(3'd1), 1'b0, 1'b0, 1'b0);
    e = f_st(3'd6);
    e.trp = 1'b1;
    for (int i = 0; i < 3; i++) step("trap held", e, 1'b1, 1'b1, 1'b0);
    do_reset("reset after trap");
`else
    fetch("illegal", 32'h0000_007F, 0);
    e = f_st(3'd1);
    e.pcw = 1'b1;
    e.pcc = 2'b01;
    step("illegal nop", e, 1'b0, 1'b0, 1'b0);
`endif

    // Instruction-fetch stalls: short, and ready exactly at the limit cycle
    run_alu("add-fw2",  32'h0000_0033, 2, 4'b0000, 1'b0, 1'b0);
    run_alu("add-fw15", 32'h0000_0033, TMO, 4'b0000, 1'b0, 1'b0);

    // Reset during EXEC of a jal: everything drops without waiting for a clock
    fetch("jal-abort", 32'h0000_006F, 0);
    step("jal-abort decode", f_st(3'd1), 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    step("abort in exec", f_st(3'd0), 1'b1, 1'b1, 1'b1);
    step("abort held", f_st(3'd0), 1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
    run_alu("add after abort", 32'h0000_0033, 0, 4'b0000, 1'b0, 1'b0);

    // Fetch timeout: 16 stalled FETCH cycles, then sticky FAULT
    instr = 32'h0000_0033;
    for (int i = 0; i < TMO + 1; i++) step("imem stall", f_fetch(1'b0), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("imem fault", f_fault(), 1'b1, 1'b1, 1'b0);
    do_reset("reset after imem fault");

    // Data timeout after a stalled fetch; the counter restarts on MEM entry
    fetch("lw-to", 32'h0000_2003, 5);
    step("lw-to decode", f_st(3'd1), 1'b0, 1'b0, 1'b0);
    step("lw-to exec", f_exec(4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TMO + 1; i++) step("dmem stall", f_mem(1'b1, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step("dmem fault", f_fault(), 1'b1, 1'b1, 1'b0);
    do_reset("reset after dmem fault");

    run_alu("add final", 32'h0000_0033, 0, 4'b0000, 1'b0, 1'b0);
    step("fetch after final", f_fetch(1'b0), 1'b0, 1'b0, 1'b0);

    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multi-cycle successor to the single-cycle control decoder for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback states, and handshakes with instruction and data memories that may stall. It latches the decoded instruction fields and drives the same datapath controls as the single-cycle decoder, gated per state. It adds memory-timeout fault detection, and optionally an illegal-instruction trap.

## Interface
- ALU_OP_W, 4: width of `alu_op`; must be ≥4, upper bits driven 0
- MEM_TIMEOUT, 15: maximum wait cycles on a ready input before fault; range 1..255
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction memory read data; sampled when `imem_ready`=1 in FETCH
- imem_ready  in  1  instruction fetch complete
- dmem_ready  in  1  data access complete
- branch_taken  in  1  ALU compare result, valid in EXEC
- fetch_req  out  1  instruction fetch request
- ir_write  out  1  instruction register load strobe
- pc_write  out  1  PC update strobe
- pc_control  out  2  PC source: 01 = +4, 10 = jump, 11 = branch, 00 = hold
- imm_en, rf_write_en, mem_read_en, mem_write_en, sign_extender_en, sign_extender_type  out  1 each  datapath controls; `sign_extender_type`: 1 = unsigned
- alu_op  out  ALU_OP_W  ALU operation
- mem_fault  out  1  sticky memory timeout flag
- trap  out  1  sticky illegal-instruction flag
- state  out  3  current state, for debug

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5, TRAP=6.
- **FETCH:** `fetch_req`=1 until `imem_ready`. On `imem_ready`: `ir_write`=1, latch `instr[6:2]`, `funct3`, `instr[30]`, then go to DECODE.
- **DECODE:** classify the instruction as LUI/AUIPC (0x101), OP-IMM (00100), OP (01100), LOAD (00000), STORE (01000), JAL (11011), JALR (11001), BRANCH (11000), or illegal. Legal instructions go to EXEC.
- **EXEC:** drive `imm_en`=1 for all classes except OP. Drive `sign_extender_en`=1 for all classes except OP.
- **EXEC, `alu_op` encoding:**
  - add 0000, sub 0001, sll 0010, srl 0100, sra 0101, xor 0110, or 0111, and 1000
  - slt/sltu 1101
  - beq 1001, bne 1010, blt/bltu 1011, bge/bgeu 1100
  - LOAD, STORE, JAL, JALR, LUI and AUIPC use add.
  - sub applies only to OP with `instr[30]`=1. sra applies when `funct3`=101 and `instr[30]`=1.
- **EXEC, `sign_extender_type`:** 1 for sltiu, sltu, bltu, bgeu, and for loads with `funct3[2]`=1. 0 otherwise.
- **EXEC, next state:**
  - OP, OP-IMM, LUI/AUIPC: go to WB.
  - LOAD, STORE: go to MEM.
  - BRANCH: `pc_write`=1; `pc_control`=11 if `branch_taken`, else 01; go to FETCH.
  - JAL, JALR: `rf_write_en`=1, `pc_write`=1, `pc_control`=10; go to FETCH.
- **MEM:** drive `mem_read_en` (LOAD) or `mem_write_en` (STORE) until `dmem_ready`.
  - LOAD then goes to WB.
  - STORE asserts `pc_write`=1, `pc_control`=01 in the `dmem_ready` cycle, then goes to FETCH.
- **WB:** `rf_write_en`=1, `pc_write`=1, `pc_control`=01; go to FETCH.
- **Timeout counter:** 8-bit, cleared on entry to FETCH or MEM, increments each cycle the relevant ready input is 0.
  - If it equals MEM_TIMEOUT and ready is still 0, go to FAULT.
  - Ready in that same cycle takes priority over the timeout.
- **FAULT:** `mem_fault`=1. All other outputs 0. Exits only on reset.
- In every state, any output not named above is 0.

## Timing
- Async reset: while `rst_n`=0, all outputs are 0 and state=FETCH.
- After reset release, `fetch_req`=1 in the first cycle.
- All outputs are combinational decode of the registered state and latched fields. There is no input-to-output path except:
  - `imem_ready` → `ir_write`
  - `dmem_ready` → STORE `pc_write`
  - `branch_taken` → `pc_control`
- Cycles per instruction with zero memory wait: OP/OP-IMM/LUI/AUIPC 4, LOAD 5, STORE 4, BRANCH/JAL/JALR 3. Each wait cycle on a ready input adds 1.
- `rst_n` assertion mid-instruction aborts it immediately. No partial strobe is issued afterward.

## Configuration
- `MCU_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in DECODE goes to TRAP.
  - TRAP asserts `trap`=1 with all other outputs 0, and holds until reset.
- `MCU_ILLEGAL_TRAP_EN` undefined:
  - An illegal opcode is a NOP: DECODE asserts `pc_write`=1, `pc_control`=01, then goes to FETCH.
  - `trap` is tied to 0 and TRAP is unreachable.

## Test plan
- Reset with `rst_n`=0 mid-EXEC → all outputs 0 asynchronously; after release, state=0 and `fetch_req`=1.
- `add` (opcode 0110011, `funct3`=000, `instr[30]`=0), ready always 1 → states 0,1,2,4,0; EXEC `alu_op`=0000; WB `rf_write_en`=1, `pc_write`=1, `pc_control`=01.
- `lbu` (opcode 0000011, `funct3`=100), `dmem_ready` delayed 3 cycles:
  - MEM lasts 4 cycles with `mem_read_en`=1 and `sign_extender_type`=1.
  - Then WB.
  - Total 8 cycles.
- `bltu` (opcode 1100011, `funct3`=110):
  - With `branch_taken`=1 → EXEC `alu_op`=1011, `pc_control`=11.
  - Repeat with `branch_taken`=0 → `pc_control`=01.
- `imem_ready` held 0 with MEM_TIMEOUT=15 → FAULT entered after 16 FETCH cycles, `mem_fault`=1 sticky. Ready arriving in cycle 16 instead → normal DECODE.
- Opcode 1111111:
  - With `MCU_ILLEGAL_TRAP_EN` → `trap`=1, state=6, held.
  - Without → one `pc_write` with `pc_control`=01, return to FETCH.
